// File: rtl/dram_req_queue_pkg.sv
// Shared constants, FSM state type and address-width helpers for the DRAM request queue.
package dram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd
    } state_e;

    function automatic int unsigned col_width(input int unsigned columns,
                                              input int unsigned dram_data_width);
        return $clog2(columns / dram_data_width);
    endfunction

    function automatic int unsigned row_width(input int unsigned rows);
        return $clog2(rows);
    endfunction

    function automatic int unsigned bank_width(input int unsigned banks);
        return $clog2(banks);
    endfunction

    // Address layout is {bank, row, col}.
    function automatic int unsigned u_addr_width(input int unsigned banks,
                                                 input int unsigned rows,
                                                 input int unsigned columns,
                                                 input int unsigned dram_data_width);
        return bank_width(banks) + row_width(rows) + col_width(columns, dram_data_width);
    endfunction

endpackage

// File: rtl/dram_req_queue_if.sv
// Host request/response and controller command signals of the DRAM request queue.
interface dram_req_queue_if #(
    parameter int unsigned AddrWidth  = 12,
    parameter int unsigned DataWidth  = 2,
    parameter int unsigned CountWidth = 3
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_cmd;
    logic [AddrWidth-1:0]  req_addr;
    logic [DataWidth-1:0]  req_data;
    logic                  rsp_valid;
    logic [DataWidth-1:0]  rsp_data;
    logic [CountWidth-1:0] q_count;
    logic                  q_full;
    logic                  q_empty;

    logic                  u_rst_n;
    logic                  u_en;
    logic                  u_cmd;
    logic [AddrWidth-1:0]  u_addr;
    logic [DataWidth-1:0]  u_data_i;
    logic                  u_busy;
    logic                  u_cmd_ack;
    logic                  u_data_valid;
    logic [DataWidth-1:0]  u_data_o;

    modport slave (
        input  req_valid, req_cmd, req_addr, req_data,
        input  u_busy, u_cmd_ack, u_data_valid, u_data_o,
        output req_ready, rsp_valid, rsp_data, q_count, q_full, q_empty,
        output u_rst_n, u_en, u_cmd, u_addr, u_data_i
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_data,
        output u_busy, u_cmd_ack, u_data_valid, u_data_o,
        input  req_ready, rsp_valid, rsp_data, q_count, q_full, q_empty,
        input  u_rst_n, u_en, u_cmd, u_addr, u_data_i
    );

endinterface

// File: rtl/dram_req_fifo.sv
// Synchronous FIFO with registered count/full/empty and an unregistered head output.
module dram_req_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrWidth   = $clog2(Depth),
    localparam int unsigned CountWidth = PtrWidth + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [Width-1:0]      wr_data,
    output logic [Width-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [CountWidth-1:0] count
);

    logic [Width-1:0]      mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  full_q, empty_q;
    logic                  push_en, pop_en;

    assign push_en = push && !full_q;
    assign pop_en  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (pop_en && !push_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CountWidth'(Depth));
            empty_q <= (count_d == '0);
        end
    end

    // Storage is not reset; only valid entries are ever observed at the head.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/dram_req_queue.sv
// Buffers host requests and issues them in order to the DRAM controller; returns read data.
module dram_req_queue
    import dram_pkg::*;
#(
    parameter int unsigned NUMBER_OF_COLUMNS = 8,
    parameter int unsigned NUMBER_OF_ROWS    = 128,
    parameter int unsigned NUMBER_OF_BANKS   = 8,
    parameter int unsigned U_DATA_WIDTH      = 2,
    parameter int unsigned DRAM_DATA_WIDTH   = 2,
    parameter int unsigned QUEUE_DEPTH       = 4
) (
    input  logic             u_clk,
    input  logic             u_rst,
    dram_req_queue_if.slave  bus
);

    localparam int unsigned U_ADDR_WIDTH = u_addr_width(NUMBER_OF_BANKS, NUMBER_OF_ROWS,
                                                        NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH);
    localparam int unsigned EntryWidth = 1 + U_ADDR_WIDTH + U_DATA_WIDTH;
    localparam int unsigned CountWidth = $clog2(QUEUE_DEPTH) + 1;

    logic                    push, pop;
    logic                    fifo_full, fifo_empty;
    logic [CountWidth-1:0]   fifo_count;
    logic [EntryWidth-1:0]   entry, head;
    logic                    head_cmd;
    logic [U_ADDR_WIDTH-1:0] head_addr;
    logic [U_DATA_WIDTH-1:0] head_data;

    state_e                  state_q, state_d;
    logic                    u_en;
    logic                    capture;
    logic                    rsp_valid_q;
    logic [U_DATA_WIDTH-1:0] rsp_data_q;

    assign entry = {bus.req_cmd, bus.req_addr, bus.req_data};
    assign push  = bus.req_valid && !fifo_full;

    dram_req_fifo #(
        .Width (EntryWidth),
        .Depth (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (u_clk),
        .rst     (u_rst),
        .push    (push),
        .pop     (pop),
        .wr_data (entry),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_cmd  = head[EntryWidth-1];
    assign head_addr = head[U_DATA_WIDTH +: U_ADDR_WIDTH];
    assign head_data = head[U_DATA_WIDTH-1:0];

    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !bus.u_busy) state_d = StIssue;
            end
            // Busy is deliberately ignored here: once issued, only the ack moves us on.
            StIssue: begin
                if (bus.u_cmd_ack) begin
                    if (head_cmd == CMD_WRITE || bus.u_data_valid) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitRd;
                    end
                end
            end
            StWaitRd: begin
                if (bus.u_data_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        u_en    = (state_q == StIssue);
        pop     = u_en && bus.u_cmd_ack;
        capture = (pop && head_cmd == CMD_READ && bus.u_data_valid) ||
                  (state_q == StWaitRd && bus.u_data_valid);
    end

    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= capture;
            if (capture) rsp_data_q <= bus.u_data_o;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.q_full    = fifo_full;
    assign bus.q_empty   = fifo_empty;
    assign bus.q_count   = fifo_count;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.u_rst_n   = ~u_rst;
    assign bus.u_en      = u_en;
    assign bus.u_cmd     = head_cmd;
    assign bus.u_addr    = head_addr;
    assign bus.u_data_i  = head_data;

endmodule

// File: doc/dram_req_queue.md
# dram_req_queue

Request queue and issue sequencer placed directly upstream of `dram_controller`. It buffers up to `QUEUE_DEPTH` read/write requests from a host over a valid/ready handshake. It issues the requests one at a time and in order on the controller's `u_*` command interface, following the controller's busy/ack protocol. Read data is returned to the host in request order as a single-cycle response pulse.

## Interface
Parameters:
- `NUMBER_OF_COLUMNS`, 8, columns per row
- `NUMBER_OF_ROWS`, 128, rows per bank
- `NUMBER_OF_BANKS`, 8, banks
- `U_DATA_WIDTH`, 2, user data width
- `DRAM_DATA_WIDTH`, 2, DRAM data width
- `QUEUE_DEPTH`, 4, FIFO entries; power of two, at least 2
- `U_ADDR_WIDTH`, derived, not overridden: clog2(BANKS) + clog2(ROWS) + clog2(COLUMNS/DRAM_DATA_WIDTH); address format is {bank, row, col}

Ports:
- `u_clk`  in  1  the single clock
- `u_rst`  in  1  reset, synchronous, active-high; the top level drives the controller's `u_rst_n` as ~`u_rst`
- `req_valid`  in  1  host request valid
- `req_ready`  out  1  equals !`q_full`
- `req_cmd`  in  1  0 = read, 1 = write
- `req_addr`  in  U_ADDR_WIDTH  request address
- `req_data`  in  U_DATA_WIDTH  write data; ignored for reads
- `rsp_valid`  out  1  read-data pulse, one cycle; no backpressure
- `rsp_data`  out  U_DATA_WIDTH  read data
- `q_count`  out  clog2(QUEUE_DEPTH)+1  current occupancy
- `q_full`  out  1  queue full
- `q_empty`  out  1  queue empty
- `u_en`  out  1  to controller: command present
- `u_cmd`  out  1  to controller: command
- `u_addr`  out  U_ADDR_WIDTH  to controller: address
- `u_data_i`  out  U_DATA_WIDTH  to controller: write data
- `u_busy`  in  1  from controller: busy
- `u_cmd_ack`  in  1  from controller: command acknowledge
- `u_data_valid`  in  1  from controller: read data valid
- `u_data_o`  in  U_DATA_WIDTH  from controller: read data

## Operation
- **Push:** on `req_valid && req_ready`, write {cmd, addr, data} at the tail.
  - When full, `req_ready` = 0 even if a pop occurs in the same cycle.
- **`u_cmd`/`u_addr`/`u_data_i`:** driven from the FIFO head; stable while the head is unchanged.
- **FSM states:** IDLE, ISSUE, WAIT_RD.
  - IDLE → ISSUE when !`q_empty` && !`u_busy`.
  - ISSUE: `u_en` = 1 and the head is held until `u_cmd_ack` = 1. On ack, pop the head.
    - Write: ack → IDLE.
    - Read without `u_data_valid` in the ack cycle: ack → WAIT_RD.
    - Read with `u_data_valid` in the ack cycle: capture `u_data_o` and go to IDLE.
  - `u_busy` asserting during ISSUE has no effect; the FSM keeps waiting for ack.
  - WAIT_RD: on `u_data_valid`, capture `u_data_o` into `rsp_data`, then → IDLE.
- **`u_en`:** 1 only in ISSUE.
- **Ignored inputs:** `u_data_valid` outside ISSUE/WAIT_RD, and `u_cmd_ack` outside ISSUE.
- **Reset (`u_rst`), including mid-operation:** FIFO pointers and count are cleared, FSM → IDLE, and any in-flight request is discarded.
- **Reset values:** `u_en` = 0, `rsp_valid` = 0, `rsp_data` = 0, `q_count` = 0, `q_empty` = 1, `q_full` = 0, `req_ready` = 1. Storage contents are don't-care.
- **Pointers:** clog2(QUEUE_DEPTH) bits, wrapping modulo depth. `q_count` increments and decrements independently, so a simultaneous push and pop leaves it unchanged.

## Timing
- A request accepted at edge N makes the queue non-empty after N.
- If `u_busy` = 0, the FSM enters ISSUE at edge N+1, so `u_en` is high from the cycle after N+1.
- Pop and state change occur at the edge sampling `u_cmd_ack` = 1. `u_en` is low in the following cycle.
- A new issue requires `u_busy` = 0 to be sampled in IDLE, which guarantees at least one idle cycle between commands.
- `rsp_valid` is registered: high for exactly one cycle, the cycle after `u_data_valid` is sampled.
- `q_count`, `q_full` and `q_empty` are registered and reflect the state after the previous edge.

## Structure
- Package `dram_pkg` holds:
  - `CMD_READ` = 0, `CMD_WRITE` = 1
  - the FSM state enum
  - width helper functions for U_ADDR_WIDTH, COLUMN/ROW/BANK widths
- Sub-module `dram_req_fifo`: synchronous FIFO with parameters width and depth, ports push/pop/full/empty/count, and a head output that is not registered.
- `dram_req_queue` contains the FSM and the response register.

## Test plan
- Controller model always idle, acks 2 cycles after `u_en`. Push write addr 0x0A5, data 2'b10 → `u_en`=1, `u_cmd`=1, `u_addr`=0x0A5, `u_data_i`=2, `rsp_valid` never set.
- Write 2'b11 to 0x123, then read 0x123. Model returns `u_data_valid` 3 cycles after ack with data 3 → exactly one `rsp_valid` pulse, `rsp_data`=3.
- Push 4 requests back-to-back with the model stalled busy → `q_full`=1 and `req_ready`=0. A 5th push is refused, `q_count` stays 4. Release busy → all 4 are issued in push order.
- Read where the model raises ack and `u_data_valid` in the same cycle with data 1 → `rsp_valid` next cycle with 1, FSM goes straight to IDLE.
- Assert `u_rst` for one cycle while in WAIT_RD with 2 entries queued → next cycle `u_en`=0, `q_empty`=1, `q_count`=0, and no `rsp_valid` for the abandoned read.
- Run 1000 random commands against a reference memory model → all read responses match, in order, and `u_en` is never high while `u_busy` was sampled high in IDLE.
